cla_op_sequencer: RTL



---
 rtl/cla_seq_pkg.sv | 34 +++
 rtl/cla_seq_fifo.sv | 50 +++++
 rtl/cla_op_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cla_seq_pkg.sv
// Shared types for the CLA operand sequencer: FSM states, counter type, result entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Optional macro CLA_SEQ_OVF_EN adds the ovf bit to result entries.
package cla_seq_pkg;

   localparam int CLA_SEQ_WIDTH  = 16;
   localparam int CLA_SEQ_SETTLE = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      CAPTURE = 2'd2
   } seq_state_t;

   // Settle counter; 4 bits covers the legal 1..15 range.
   typedef logic [3:0] cnt_t;

   // Buffer entry at the default operand width.
   typedef struct packed {
      logic [CLA_SEQ_WIDTH-1:0] sum;
      logic                     cout;
      logic                     zero;
      logic                     neg;
`ifdef CLA_SEQ_OVF_EN
      logic                     ovf;
`endif
   } res_entry_t;

   // Signed overflow: operands agree in sign but the sum does not.
   function automatic logic ovf_flag(input logic a_msb, input logic b_msb, input logic s_msb);
      return (a_msb == b_msb) && (s_msb != a_msb);
   endfunction

endpackage

// File: rtl/cla_seq_fifo.sv
// Two-entry in-order result buffer with push/pop and full/empty status.
// Latency: a pushed entry is visible at the head on the cycle after the push edge.
// Backpressure: pushes while full and pops while empty are ignored; push+pop in one cycle both apply.
module cla_seq_fifo #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [DW-1:0] wr_dat,
   input  logic          pop,
   output logic [DW-1:0] rd_dat,
   output logic          full,
   output logic          empty
);

   logic [DW-1:0] mem [2];
   logic          wp;
   logic          rp;
   logic [1:0]    cnt;
   logic          do_push;
   logic          do_pop;

   assign full    = (cnt == 2'd2);
   assign empty   = (cnt == 2'd0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_dat  = mem[rp];

   // Storage, pointers and occupancy; entries clear on reset so the head reads zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wp     <= 1'b0;
         rp     <= 1'b0;
         cnt    <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wp] <= wr_dat;
            wp      <= ~wp;
         end
         if (do_pop) begin
            rp <= ~rp;
         end
         cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

endmodule

// File: rtl/cla_op_sequencer.sv
// Drives operand pairs onto the CLA, holds them SETTLE_CYCLES, then captures sum/carry/flags.
// Latency: SETTLE_CYCLES+1 cycles accept-to-out_valid; one op per SETTLE_CYCLES+2 cycles.
// Backpressure: in_ready drops while an op is in flight or the 2-entry buffer is full. Macro: CLA_SEQ_OVF_EN.
module cla_op_sequencer
   import cla_seq_pkg::*;
#(
   parameter int WIDTH         = CLA_SEQ_WIDTH,
   parameter int SETTLE_CYCLES = CLA_SEQ_SETTLE
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [WIDTH-1:0] adder_a,
   output logic [WIDTH-1:0] adder_b,
   input  logic [WIDTH-1:0] adder_s,
   input  logic             adder_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_zero,
   output logic             out_neg,
   output logic             out_ovf
);

   // Entry layout sized to this instance's WIDTH.
   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             zero;
      logic             neg;
`ifdef CLA_SEQ_OVF_EN
      logic             ovf;
`endif
   } entry_t;

   localparam cnt_t SETTLE_LD = cnt_t'(SETTLE_CYCLES);

   seq_state_t state;
   seq_state_t nxt;
   cnt_t       cnt;
   logic       rdy_en;
   logic       load;
   logic       push;
   logic       pop;
   logic       full;
   logic       empty;
   entry_t     wr_e;
   entry_t     hd_e;

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   // Next-state and handshake decode.
   always_comb begin
      nxt      = state;
      load     = 1'b0;
      push     = 1'b0;
      in_ready = 1'b0;
      case (state)
         IDLE: begin
            in_ready = rdy_en && !full;
            if (in_valid && in_ready) begin
               load = 1'b1;
               nxt  = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt <= cnt_t'(1)) nxt = CAPTURE;
         end
         CAPTURE: begin
            push = 1'b1;
            nxt  = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // Operand hold registers, settle counter, and the post-reset ready enable
   // (keeps in_ready low until the first edge after reset is released).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         adder_a <= '0;
         adder_b <= '0;
         cnt     <= '0;
         rdy_en  <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
         if (load) begin
            adder_a <= in_a;
            adder_b <= in_b;
            cnt     <= SETTLE_LD;
         end else if (state == SETTLE) begin
            cnt <= cnt - cnt_t'(1);
         end
      end
   end

   // Result entry assembled from the settled adder outputs and held operands.
   always_comb begin
      wr_e      = '0;
      wr_e.sum  = adder_s;
      wr_e.cout = adder_cout;
      wr_e.zero = (adder_s == '0);
      wr_e.neg  = adder_s[WIDTH-1];
`ifdef CLA_SEQ_OVF_EN
      wr_e.ovf  = ovf_flag(adder_a[WIDTH-1], adder_b[WIDTH-1], adder_s[WIDTH-1]);
`endif
   end

   assign pop = out_valid && out_ready;

   cla_seq_fifo #(
      .DW($bits(entry_t))
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push   (push),
      .wr_dat (wr_e),
      .pop    (pop),
      .rd_dat (hd_e),
      .full   (full),
      .empty  (empty)
   );

   assign out_valid = !empty;
   assign out_sum   = hd_e.sum;
   assign out_cout  = hd_e.cout;
   assign out_zero  = hd_e.zero;
   assign out_neg   = hd_e.neg;
`ifdef CLA_SEQ_OVF_EN
   assign out_ovf   = hd_e.ovf;
`else
   assign out_ovf   = 1'b0;
`endif

endmodule
